hazard_stall_ctrl: RTL and testbench
====================================

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-high.
REQ-002 Parameter: WAIT_LIMIT, default 8'd255, consecutive instruction-memory wait cycles before timeout is flagged.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  asynchronous active-high reset.
REQ-005 id_rs  in  5  rs field of the instruction held in the IF/ID register.
REQ-006 id_rt  in  5  rt field of the instruction held in the IF/ID register.
REQ-007 id_use_rs / id_use_rt  in  1 each  ID instruction reads rs / rt.
REQ-008 ex_load  in  1  instruction in EX is a load (e.g. LBU).
REQ-009 ex_rt  in  5  destination register of the EX load.
REQ-010 imem_ready  in  1  instruction memory word valid this cycle.
REQ-011 pc_le  out  1  PC load enable.
REQ-012 ifid_le  out  1  IF/ID register load enable.
REQ-013 idex_bubble  out  1  force all-zero control (NOP) into ID/EX.
REQ-014 state  out  2  current FSM state.
REQ-015 timeout  out  1  sticky instruction-memory timeout flag.
REQ-016 stall_count  out  16  cycles with pc_le=0 (see Configuration).

Function
REQ-017 Load-use hazard (lu) SHALL be: ex_load && ex_rt!=0 && ((id_use_rs && id_rs==ex_rt) || (id_use_rt && id_rt==ex_rt)).
REQ-018 FSM states SHALL be RUN=2'b00, LU_STALL=2'b01, IMEM_WAIT=2'b10; 2'b11 SHALL transition to RUN with RUN outputs.
REQ-019 Outputs pc_le, ifid_le, idex_bubble SHALL be combinational (Mealy) from state and inputs; state, counters, timeout registered.
REQ-020 RUN, imem_ready=0: pc_le=0, ifid_le=0, idex_bubble=1; next IMEM_WAIT (takes priority over lu).
REQ-021 RUN, imem_ready=1, lu=1: pc_le=0, ifid_le=0, idex_bubble=1; next LU_STALL.
REQ-022 RUN, imem_ready=1, lu=0: pc_le=1, ifid_le=1, idex_bubble=0; stay RUN.
REQ-023 LU_STALL: lu SHALL be ignored (load has advanced, forwarding covers it); behave as RUN with lu forced 0; exactly one bubble per load-use.
REQ-024 IMEM_WAIT, imem_ready=0: pc_le=0, ifid_le=0, idex_bubble=1; stay.
REQ-025 IMEM_WAIT, imem_ready=1: pc_le=1, ifid_le=1, idex_bubble=0; next RUN; lu ignored this cycle.
REQ-026 An 8-bit wait counter SHALL increment each cycle spent in IMEM_WAIT with imem_ready=0, saturate at 8'hFF, and clear on any cycle not in that condition.
REQ-027 timeout SHALL set the cycle after wait counter equals WAIT_LIMIT and hold until reset; it SHALL NOT alter stall behaviour.
REQ-028 pc_le and ifid_le SHALL always be equal.

Reset
REQ-029 On reset: state=RUN, wait counter=0, timeout=0, stall_count=0; while reset high pc_le=0, ifid_le=0, idex_bubble=1.
REQ-030 Reset mid-stall SHALL abandon the stall immediately; first cycle after release evaluates as RUN.

Configuration
REQ-031 Macro HAZARD_STATS_EN defined: stall_count SHALL increment every cycle pc_le=0 (reset excluded), saturating at 16'hFFFF.
REQ-032 HAZARD_STATS_EN undefined: stall_count port SHALL exist and be tied to 16'h0000, no counter flops.

Structure
REQ-033 Shared pipeline package SHALL hold FSM state encodings, REG_ZERO=5'd0, and the default WAIT_LIMIT constant.
REQ-034 The lu compare SHALL be a combinational sub-module load_use_detect instantiated once.

Verification
REQ-035 ex_load=1, ex_rt=5'd8, id_rs=5'd8, id_use_rs=1, imem_ready=1 -> one cycle pc_le=0, idex_bubble=1, state LU_STALL next, then pc_le=1.
REQ-036 Same as REQ-035 but ex_rt=5'd0 -> no stall, pc_le stays 1.
REQ-037 imem_ready low 3 cycles from RUN -> 3 cycles pc_le=0/idex_bubble=1, state IMEM_WAIT, RUN after ready; stall_count=3 with HAZARD_STATS_EN.
REQ-038 WAIT_LIMIT=4, imem_ready held 0 for 7 cycles -> timeout rises, stays 1 after ready returns until reset.
REQ-039 lu=1 and imem_ready=0 same cycle -> IMEM_WAIT entered, no LU_STALL afterwards.
REQ-040 Assert reset during IMEM_WAIT -> state RUN, timeout=0, stall_count=0 immediately (asynchronous).

Source files
------------

// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared pipeline definitions for the hazard/stall controller: FSM encodings,
// the zero-register index and the default instruction-memory wait limit.
package hazard_stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'b00,
    LU_STALL  = 2'b01,
    IMEM_WAIT = 2'b10
  } state_e;

  localparam logic [4:0]  REG_ZERO           = 5'd0;
  localparam logic [7:0]  DEFAULT_WAIT_LIMIT = 8'd255;
  localparam logic [7:0]  WAIT_CNT_MAX       = 8'hFF;
  localparam logic [15:0] STALL_CNT_MAX      = 16'hFFFF;

endpackage

// File: rtl/hazard_stall_ctrl_load_use_detect.sv
// Combinational load-use hazard compare between the EX load and the ID operands.
module load_use_detect
  import hazard_stall_ctrl_pkg::*;
(
  input  logic       ex_load,
  input  logic [4:0] ex_rt,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  output logic       lu
);

  always_comb begin
    lu = ex_load && (ex_rt != REG_ZERO) &&
         ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
  end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall controller: load-use bubbles, instruction-memory wait stalls,
// sticky wait timeout. Optional stall statistics counter under HAZARD_STATS_EN.
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter logic [7:0] WAIT_LIMIT = DEFAULT_WAIT_LIMIT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_use_rs,
  input  logic        id_use_rt,
  input  logic        ex_load,
  input  logic [4:0]  ex_rt,
  input  logic        imem_ready,
  output logic        pc_le,
  output logic        ifid_le,
  output logic        idex_bubble,
  output logic [1:0]  state,
  output logic        timeout,
  output logic [15:0] stall_count
);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic       timeout_q, timeout_d;
  logic       lu;
  logic       stall;
  logic       in_wait;

  load_use_detect u_load_use_detect (
    .ex_load   (ex_load),
    .ex_rt     (ex_rt),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .lu        (lu)
  );

  always_comb begin
    stall   = 1'b1;
    state_d = RUN;
    in_wait = 1'b0;
    if (!reset) begin
      case (state_q)
        RUN: begin
          if (!imem_ready) begin
            state_d = IMEM_WAIT;
          end else if (lu) begin
            state_d = LU_STALL;
          end else begin
            stall = 1'b0;
          end
        end
        // The load has moved on to MEM; forwarding covers the dependency.
        LU_STALL: begin
          if (!imem_ready) begin
            state_d = IMEM_WAIT;
          end else begin
            stall = 1'b0;
          end
        end
        IMEM_WAIT: begin
          if (!imem_ready) begin
            state_d = IMEM_WAIT;
            in_wait = 1'b1;
          end else begin
            stall = 1'b0;
          end
        end
        default: begin
          stall = !imem_ready || lu;
        end
      endcase
    end

    pc_le       = !stall;
    ifid_le     = !stall;
    idex_bubble = stall;

    if (in_wait) begin
      wait_d = (wait_q == WAIT_CNT_MAX) ? wait_q : wait_q + 8'd1;
    end else begin
      wait_d = '0;
    end
    timeout_d = timeout_q || (wait_q == WAIT_LIMIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= RUN;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign state   = state_q;
  assign timeout = timeout_q;

`ifdef HAZARD_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && (stall_cnt_q != STALL_CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Self-checking bench for hazard_stall_ctrl: vector table, corner sequences,
// and randomized traffic against a rule-level reference model.
module tb_hazard_stall_ctrl;

  localparam logic [7:0] LIMIT = 8'd4;
`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_use_rs, id_use_rt, ex_load, imem_ready;
  logic        pc_le, ifid_le, idex_bubble, timeout;
  logic [1:0]  state;
  logic [15:0] stall_count;

  hazard_stall_ctrl #(.WAIT_LIMIT(LIMIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .ex_load     (ex_load),
    .ex_rt       (ex_rt),
    .imem_ready  (imem_ready),
    .pc_le       (pc_le),
    .ifid_le     (ifid_le),
    .idex_bubble (idex_bubble),
    .state       (state),
    .timeout     (timeout),
    .stall_count (stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 = running, 1 = just bubbled for a load-use, 2 = waiting on imem
  int m_mode, m_wait, m_stalls;
  bit m_to;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_mode = 0; m_wait = 0; m_stalls = 0; m_to = 1'b0;
  endtask

  function automatic bit model_lu();
    return ex_load && (ex_rt != 5'd0) &&
           ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt));
  endfunction

  function automatic bit model_stall();
    return reset || !imem_ready || (m_mode == 0 && model_lu());
  endfunction

  task automatic drive(input bit rst, input bit ld, input logic [4:0] ert,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input bit urs, input bit urt, input bit rdy);
    reset = rst; ex_load = ld; ex_rt = ert; id_rs = rs; id_rt = rt;
    id_use_rs = urs; id_use_rt = urt; imem_ready = rdy;
    if (rst) model_clear();
    @(negedge clk);
  endtask

  task automatic tick();
    int  n_mode, n_wait, n_stalls;
    bit  n_to;
    if (reset) begin
      n_mode = 0; n_wait = 0; n_stalls = 0; n_to = 1'b0;
    end else begin
      if (!imem_ready)                   n_mode = 2;
      else if (m_mode == 0 && model_lu()) n_mode = 1;
      else                               n_mode = 0;
      n_wait   = (m_mode == 2 && !imem_ready) ? ((m_wait < 255) ? m_wait + 1 : 255) : 0;
      n_to     = m_to || (m_wait == int'(LIMIT));
      n_stalls = (model_stall() && m_stalls < 65535) ? m_stalls + 1 : m_stalls;
    end
    @(posedge clk);
    m_mode = n_mode; m_wait = n_wait; m_to = n_to; m_stalls = n_stalls;
    #1;
  endtask

  task automatic check_model(input string tag);
    bit s;
    s = model_stall();
    chk({tag, ".pc_le"}, 16'(pc_le), 16'(!s));
    chk({tag, ".ifid_le"}, 16'(ifid_le), 16'(!s));
    chk({tag, ".bubble"}, 16'(idex_bubble), 16'(s));
    chk({tag, ".state"}, 16'(state), 16'(m_mode));
    chk({tag, ".timeout"}, 16'(timeout), 16'(m_to));
    chk({tag, ".stall_count"}, stall_count, STATS ? 16'(m_stalls) : 16'h0);
  endtask

  task automatic do_reset();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    tick();
  endtask

  typedef struct {
    bit         ld;
    logic [4:0] ert, rs, rt;
    bit         urs, urt, rdy;
    bit         e_pc, e_bub;
    logic [1:0] e_st;
  } vec_t;

  function automatic vec_t mk(bit ld, logic [4:0] ert, logic [4:0] rs, logic [4:0] rt,
                              bit urs, bit urt, bit rdy, bit e_pc, bit e_bub,
                              logic [1:0] e_st);
    vec_t v;
    v.ld = ld; v.ert = ert; v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt;
    v.rdy = rdy; v.e_pc = e_pc; v.e_bub = e_bub; v.e_st = e_st;
    return v;
  endfunction

  vec_t tbl[15];

  initial begin
    tbl[0]  = mk(1, 8, 8, 0, 1, 0, 1, 0, 1, 2'd0); // load-use hit -> bubble
    tbl[1]  = mk(1, 8, 8, 0, 1, 0, 1, 1, 0, 2'd1); // LU_STALL ignores lu
    tbl[2]  = mk(1, 8, 8, 0, 1, 0, 1, 0, 1, 2'd0);
    tbl[3]  = mk(0, 8, 8, 0, 1, 0, 1, 1, 0, 2'd1);
    tbl[4]  = mk(1, 0, 0, 0, 1, 0, 1, 1, 0, 2'd0); // ex_rt = r0 never stalls
    tbl[5]  = mk(1, 0, 0, 0, 1, 1, 1, 1, 0, 2'd0);
    tbl[6]  = mk(1, 3, 3, 3, 0, 1, 1, 0, 1, 2'd0); // rt match
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd1);
    tbl[8]  = mk(1, 5, 5, 5, 0, 0, 1, 1, 0, 2'd0); // match but unused operands
    tbl[9]  = mk(1, 8, 8, 0, 1, 0, 0, 0, 1, 2'd0); // lu with imem not ready
    tbl[10] = mk(1, 8, 8, 0, 1, 0, 1, 1, 0, 2'd2); // wait exit ignores lu
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd0); // back in RUN, no LU_STALL
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'd2);
    tbl[13] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd2);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 2'd0);

    model_clear();
    drive(1, 0, 0, 0, 0, 0, 0, 1);
    chk("rst.pc_le", 16'(pc_le), 16'h0);
    chk("rst.ifid_le", 16'(ifid_le), 16'h0);
    chk("rst.bubble", 16'(idex_bubble), 16'h1);
    chk("rst.state", 16'(state), 16'h0);
    chk("rst.timeout", 16'(timeout), 16'h0);
    chk("rst.stall_count", stall_count, 16'h0);
    tick();

    for (int i = 0; i < 15; i++) begin
      drive(0, tbl[i].ld, tbl[i].ert, tbl[i].rs, tbl[i].rt,
            tbl[i].urs, tbl[i].urt, tbl[i].rdy);
      chk($sformatf("vec%0d.state", i), 16'(state), 16'(tbl[i].e_st));
      chk($sformatf("vec%0d.pc_le", i), 16'(pc_le), 16'(tbl[i].e_pc));
      chk($sformatf("vec%0d.ifid_le", i), 16'(ifid_le), 16'(tbl[i].e_pc));
      chk($sformatf("vec%0d.bubble", i), 16'(idex_bubble), 16'(tbl[i].e_bub));
      tick();
    end

    // Three imem wait cycles from RUN, then ready
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("wait3.c%0d.pc_le", i), 16'(pc_le), 16'h0);
      chk($sformatf("wait3.c%0d.bubble", i), 16'(idex_bubble), 16'h1);
      chk($sformatf("wait3.c%0d.state", i), 16'(state), (i == 0) ? 16'h0 : 16'h2);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("wait3.exit.state", 16'(state), 16'h2);
    chk("wait3.exit.pc_le", 16'(pc_le), 16'h1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("wait3.run.state", 16'(state), 16'h0);
    chk("wait3.stall_count", stall_count, STATS ? 16'd3 : 16'd0);
    tick();

    // Timeout with WAIT_LIMIT=4: counter reaches 4 after cycle 5, flag seen in cycle 6
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk($sformatf("tmo.c%0d", i), 16'(timeout), (i >= 6) ? 16'h1 : 16'h0);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      chk($sformatf("tmo.hold%0d", i), 16'(timeout), 16'h1);
      chk($sformatf("tmo.hold%0d.pc_le", i), 16'(pc_le), 16'h1);
      tick();
    end

    // Asynchronous reset in the middle of an imem wait
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("arst.pre.state", 16'(state), 16'h2);
    chk("arst.pre.timeout", 16'(timeout), 16'h1);
    #1 reset = 1'b1;
    model_clear();
    #1;
    chk("arst.state", 16'(state), 16'h0);
    chk("arst.timeout", 16'(timeout), 16'h0);
    chk("arst.stall_count", stall_count, 16'h0);
    chk("arst.pc_le", 16'(pc_le), 16'h0);
    chk("arst.bubble", 16'(idex_bubble), 16'h1);
    tick();
    drive(0, 1, 8, 8, 0, 1, 0, 1);
    chk("arst.after.state", 16'(state), 16'h0);
    chk("arst.after.pc_le", 16'(pc_le), 16'h0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    chk("arst.after2.state", 16'(state), 16'h1);
    tick();

    // Randomized traffic against the reference model
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0));
      check_model($sformatf("rnd%0d", i));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
